stopw_ctrl: RTL and testbench
=============================

# stopw_ctrl

Control and display-scan sequencer for the four-decade stopwatch datapath. It turns the two push-buttons into counter enable and clear commands through a four-state run/stop/lap FSM, and freezes the displayed time during a lap. It also multiplexes the four BCD decade values onto the single shared 7-segment decoder, one digit per 200 Hz tick. It sits between the board buttons, the decade counter chain, the decoder and the anode drivers.

## Interface
Parameters:
- DEB_TICKS, 4, number of consecutive Tick strobes a synchronized button level must hold before it is accepted (4 = 20 ms at 200 Hz); legal range 1..15

Ports:
- Clk  in  1  system clock, rising edge
- RES  in  1  asynchronous, active-low reset
- Tick  in  1  one-Clk-wide strobe at 200 Hz, used for debounce and scan
- BtnSS  in  1  raw start/stop button, active-high, asynchronous
- BtnLR  in  1  raw lap/reset button, active-high, asynchronous
- Seg1..Seg4  in  4 each  live BCD values of the decade counters; Seg1 is the least significant
- CntEN  out  1  count enable to all decades
- CntRES  out  1  synchronous clear to all decades, active-high
- Digit  out  4  BCD value to the 7-segment decoder
- SEG  out  4  anode select, one-hot active-low; bit i selects Seg(i+1)
- LapLED  out  1  high while the display is frozen

## Operation
- Each button passes through a 2-FF synchronizer and then a debouncer. The debounced level changes only after the synchronized level differs from it on DEB_TICKS consecutive Tick strobes; any bounce restarts the count.
- A 0→1 transition of a debounced level produces a single one-Clk event: evSS or evLR.
- FSM states: IDLE, RUN, STOP, LAP. All transitions are event-driven; evSS has priority, so evLR is discarded in a cycle where both events occur.
  - IDLE: evSS→RUN. evLR→IDLE with a CntRES pulse.
  - RUN: evSS→STOP. evLR→LAP, and the lap register captures Seg1..Seg4 in that same edge.
  - LAP: evSS→STOP; the display releases to live values. evLR→RUN; the display releases to live values.
  - STOP: evSS→RUN. evLR→IDLE with a CntRES pulse.
- CntEN = 1 in RUN and LAP, 0 otherwise.
- LapLED = 1 in LAP only.
- Display source is the lap register in LAP and Seg1..Seg4 otherwise.
- Scan index is 2 bits. It advances by 1 on each Tick and wraps 3→0.
  - SEG = ~(1 << idx).
  - Digit = selected source digit for idx.
  - Both are registered and update on the same edge as idx.
- Digit values are passed through unchecked; values above 9 are the decoder's concern.

## Timing
- Reset values:
  - state = IDLE
  - CntEN = 0
  - CntRES = 1, deasserted on the first Clk edge after RES rises, so the counters get one clear
  - idx = 0, SEG = 4'b1110, Digit = 0
  - LapLED = 0
  - lap register = 0
  - debounced levels = 0, debounce counters = 0
- Button latency: a raw edge is recognized after 2 Clk cycles of synchronization plus DEB_TICKS Tick strobes. evX is high in the Clk cycle after the debounced level rises. State, CntEN, LapLED and CntRES change on the next edge.
- CntRES is registered. It is high for exactly one Clk cycle, coincident with the cycle in which the state is IDLE after the clearing event.
- A held button generates exactly one event. Releasing a button generates none.
- Lap capture samples Seg1..Seg4 on the same edge that enters LAP. A counter increment on that edge is not included in the capture.
- Scan rate: each digit is shown for 5 ms; a full frame takes 20 ms.
- RES asserted mid-operation forces all reset values immediately and asynchronously. The lap value is lost.

## Structure
- Package stopw_pkg holds:
  - state enum: IDLE, RUN, STOP, LAP
  - NDIG = 4
  - anode patterns for idx 0..3
  - the BCD digit width, 4
- Sub-module btn_debounce contains the synchronizer, Tick-gated stability counter and rising-edge pulse. It is parameterized by DEB_TICKS and instantiated twice.
- FSM, lap register and scan mux live in stopw_ctrl.

## Test plan
- Reset release with no buttons pressed → CntRES = 1 for one cycle, CntEN = 0, SEG = 1110, Digit = Seg1 after the first Tick.
- BtnSS pressed, bouncing 3 times at under 4-tick intervals, then held for 4 Ticks → exactly one evSS, state RUN, CntEN = 1. Release → no state change.
- In RUN with Seg4..Seg1 = 1,2,3,4, press BtnLR → LapLED = 1. Over one scan frame Digit shows 4,3,2,1 with SEG 1110, 1101, 1011, 0111, while Seg inputs keep changing. Press BtnLR again → live values return and LapLED = 0.
- From RUN press BtnSS (→STOP, CntEN = 0), then BtnLR → one-cycle CntRES and state IDLE. A second BtnLR in IDLE → another CntRES pulse.
- Both events in the same cycle while in RUN → STOP, no lap capture, LapLED stays 0.
- Pull RES low while in LAP mid-frame → immediate IDLE, SEG = 1110, CntEN = 0, LapLED = 0. After release, CntRES pulses once.

Source files
------------

// File: rtl/stopw_pkg.sv
// stopw_pkg: shared types and constants for the stopwatch control block.
//   state_t : run/stop/lap FSM states
//   NDIG    : number of displayed decades
//   DW      : BCD digit width
//   ANODE   : active-low anode pattern per scan index
package stopw_pkg;
    typedef enum logic [1:0] {IDLE, RUN, STOP, LAP} state_t;
    localparam int NDIG = 4;
    localparam int DW = 4;
    localparam logic [NDIG-1:0][NDIG-1:0] ANODE = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchronizer, Tick-gated stability filter and rising-edge pulse.
//   Clk  in  system clock
//   RES  in  asynchronous active-low reset
//   Tick in  sampling strobe for the stability count
//   Btn  in  raw asynchronous button level
//   Ev   out one-Clk pulse when the filtered level rises
module btn_debounce #(
    parameter int DEB_TICKS = 4
) (
    input  logic Clk,
    input  logic RES,
    input  logic Tick,
    input  logic Btn,
    output logic Ev
);
    logic [1:0] sync;
    logic [3:0] cnt;
    logic       lvl;
    logic       flip;
    // The level is accepted on the Tick that completes DEB_TICKS consecutive disagreements.
    assign flip = Tick && (sync[1] != lvl) && (cnt == 4'(DEB_TICKS - 1));
    always_ff @(posedge Clk or negedge RES) begin
        if (!RES) begin
            sync <= '0;
            cnt  <= '0;
            lvl  <= 1'b0;
            Ev   <= 1'b0;
        end else begin
            sync <= {sync[0], Btn};
            Ev   <= flip && sync[1];
            if (flip) begin
                lvl <= sync[1];
                cnt <= '0;
            end else if (Tick) begin
                cnt <= (sync[1] != lvl) ? cnt + 4'd1 : 4'd0;
            end
        end
    end
endmodule

// File: rtl/stopw_ctrl.sv
// stopw_ctrl: run/stop/lap control FSM, lap freeze register and 4-digit display scan.
//   Clk, RES      clock and asynchronous active-low reset
//   Tick          200 Hz strobe for debounce and scan
//   BtnSS, BtnLR  raw start/stop and lap/reset buttons
//   Seg1..Seg4    live BCD decade values, Seg1 least significant
//   CntEN, CntRES count enable and one-cycle synchronous clear to the decades
//   Digit, SEG    scanned BCD digit and one-hot active-low anode select
//   LapLED        high while the display is frozen
module stopw_ctrl
    import stopw_pkg::*;
#(
    parameter int DEB_TICKS = 4
) (
    input  logic            Clk,
    input  logic            RES,
    input  logic            Tick,
    input  logic            BtnSS,
    input  logic            BtnLR,
    input  logic [DW-1:0]   Seg1,
    input  logic [DW-1:0]   Seg2,
    input  logic [DW-1:0]   Seg3,
    input  logic [DW-1:0]   Seg4,
    output logic            CntEN,
    output logic            CntRES,
    output logic [DW-1:0]   Digit,
    output logic [NDIG-1:0] SEG,
    output logic            LapLED
);
    state_t                     state, nxt;
    logic                       ev_ss, ev_lr, clr;
    logic [1:0]                 idx;
    logic [NDIG-1:0][DW-1:0]    live, lap, src;

    btn_debounce #(.DEB_TICKS(DEB_TICKS)) u_ss (.Clk(Clk), .RES(RES), .Tick(Tick), .Btn(BtnSS), .Ev(ev_ss));
    btn_debounce #(.DEB_TICKS(DEB_TICKS)) u_lr (.Clk(Clk), .RES(RES), .Tick(Tick), .Btn(BtnLR), .Ev(ev_lr));

    assign live = {Seg4, Seg3, Seg2, Seg1};
    assign src  = (state == LAP) ? lap : live;

    always_ff @(posedge Clk or negedge RES) begin
        if (!RES) state <= IDLE;
        else      state <= nxt;
    end

    // evSS wins; evLR is ignored in a cycle where both arrive.
    always_comb begin
        nxt    = state;
        clr    = 1'b0;
        CntEN  = (state == RUN) || (state == LAP);
        LapLED = (state == LAP);
        if (ev_ss) begin
            nxt = (state == RUN || state == LAP) ? STOP : RUN;
        end else if (ev_lr) begin
            nxt = (state == RUN) ? LAP : (state == LAP) ? RUN : IDLE;
            clr = (state == IDLE) || (state == STOP);
        end
    end

    // SEG/Digit are loaded from the current idx while idx advances, so the
    // outputs trail the index by one Tick and start at digit 0.
    always_ff @(posedge Clk or negedge RES) begin
        if (!RES) begin
            CntRES <= 1'b1;
            lap    <= '0;
            idx    <= '0;
            SEG    <= ANODE[0];
            Digit  <= '0;
        end else begin
            CntRES <= clr;
            if (state == RUN && ev_lr && !ev_ss) lap <= live;
            if (Tick) begin
                idx   <= idx + 2'd1;
                SEG   <= ANODE[idx];
                Digit <= src[idx];
            end
        end
    end
endmodule

// File: tb/tb_stopw_ctrl.sv
// tb_stopw_ctrl: randomized scoreboard bench for stopw_ctrl against a behavioural model.
module tb_stopw_ctrl;
    localparam int DEB = 4;
    localparam int TP = 4;
    localparam int M_IDLE = 0, M_RUN = 1, M_STOP = 2, M_LAP = 3;

    typedef struct {logic [3:0] seg; logic [3:0] dig;} disp_t;
    typedef struct {int en; int led; int clr;} ctl_t;

    logic       Clk = 1'b0, RES = 1'b0, Tick = 1'b0, BtnSS = 1'b0, BtnLR = 1'b0;
    logic [3:0] s [4];
    logic [3:0] lapv [4];
    logic       CntEN, CntRES, LapLED;
    logic [3:0] Digit, SEG;

    disp_t dq[$];
    ctl_t  cq[$];
    int    mode = M_IDLE, scan = 0, clr_exp = 0, clr_cnt = 0;
    int    passed = 0, total = 0;
    bit    settled = 1'b0;

    stopw_ctrl #(.DEB_TICKS(DEB)) dut (
        .Clk(Clk), .RES(RES), .Tick(Tick), .BtnSS(BtnSS), .BtnLR(BtnLR),
        .Seg1(s[0]), .Seg2(s[1]), .Seg3(s[2]), .Seg4(s[3]),
        .CntEN(CntEN), .CntRES(CntRES), .Digit(Digit), .SEG(SEG), .LapLED(LapLED)
    );

    always #5 Clk = ~Clk;

    initial begin
        forever begin
            repeat (TP - 1) @(negedge Clk);
            Tick = 1'b1;
            @(negedge Clk);
            Tick = 1'b0;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    endtask

    always @(negedge Clk) begin
        if (settled) for (int i = 0; i < 4; i++) s[i] = 4'($urandom);
    end

    // Reference scan: one digit per Tick, SEG/Digit show the digit whose turn it is.
    always @(posedge Clk or negedge RES) begin
        disp_t d;
        if (!RES) begin
            scan = 0;
        end else if (Tick) begin
            if (settled) begin
                d.seg = ~(4'b0001 << scan);
                d.dig = (mode == M_LAP) ? lapv[scan] : s[scan];
                dq.push_back(d);
            end
            scan = (scan + 1) % 4;
        end
    end

    always @(negedge Clk) begin
        ctl_t  c;
        disp_t d;
        if (RES && CntRES) clr_cnt++;
        if (cq.size() > 0) begin
            c = cq.pop_front();
            chk("cnt_en", int'(CntEN), c.en);
            chk("lap_led", int'(LapLED), c.led);
            chk("clr_pulses", clr_cnt, c.clr);
        end
        if (dq.size() > 0) begin
            d = dq.pop_front();
            chk("seg", int'(SEG), int'(d.seg));
            chk("digit", int'(Digit), int'(d.dig));
        end
    end

    task automatic push_ctl();
        ctl_t c;
        c.en  = (mode == M_RUN || mode == M_LAP) ? 1 : 0;
        c.led = (mode == M_LAP) ? 1 : 0;
        c.clr = clr_exp;
        cq.push_back(c);
    endtask

    task automatic press(input bit ss, input bit lr, input int bounces);
        settled = 1'b0;
        repeat (2) @(negedge Clk);
        for (int b = 0; b < bounces; b++) begin
            BtnSS = ss;
            BtnLR = lr;
            repeat ($urandom_range(1, 5)) @(negedge Clk);
            BtnSS = 1'b0;
            BtnLR = 1'b0;
            repeat ($urandom_range(1, 5)) @(negedge Clk);
        end
        BtnSS = ss;
        BtnLR = lr;
        repeat ((DEB + 3) * TP) @(negedge Clk);
        BtnSS = 1'b0;
        BtnLR = 1'b0;
        repeat ((DEB + 3) * TP) @(negedge Clk);
        if (ss) begin
            mode = (mode == M_RUN || mode == M_LAP) ? M_STOP : M_RUN;
        end else begin
            case (mode)
                M_IDLE: clr_exp++;
                M_RUN: begin mode = M_LAP; lapv = s; end
                M_LAP: mode = M_RUN;
                default: begin mode = M_IDLE; clr_exp++; end
            endcase
        end
        settled = 1'b1;
        push_ctl();
    endtask

    task automatic release_reset();
        @(negedge Clk);
        #1 RES = 1'b1;
        #1 chk("res_pulse_on", int'(CntRES), 1);
        @(negedge Clk);
        chk("res_pulse_off", int'(CntRES), 0);
        mode = M_IDLE;
        settled = 1'b1;
        push_ctl();
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin s[i] = '0; lapv[i] = '0; end
        repeat (3) @(negedge Clk);
        chk("rst_cnt_res", int'(CntRES), 1);
        chk("rst_cnt_en", int'(CntEN), 0);
        chk("rst_seg", int'(SEG), 4'b1110);
        chk("rst_digit", int'(Digit), 0);
        chk("rst_lap_led", int'(LapLED), 0);
        release_reset();
        repeat (3 * TP) @(negedge Clk);

        press(1, 0, 3);
        settled = 1'b0;
        @(negedge Clk);
        s[0] = 4'd4; s[1] = 4'd3; s[2] = 4'd2; s[3] = 4'd1;
        press(0, 1, 0);
        repeat (8 * TP) @(negedge Clk);
        press(0, 1, 1);
        press(1, 0, 0);
        press(0, 1, 2);
        press(0, 1, 0);
        press(1, 0, 0);
        press(1, 1, 0);
        press(1, 0, 0);
        press(0, 1, 0);
        repeat (2 * TP + 1) @(negedge Clk);

        settled = 1'b0;
        repeat (2) @(negedge Clk);
        #2 RES = 1'b0;
        #1;
        chk("async_seg", int'(SEG), 4'b1110);
        chk("async_cnt_en", int'(CntEN), 0);
        chk("async_lap_led", int'(LapLED), 0);
        chk("async_cnt_res", int'(CntRES), 1);
        chk("async_digit", int'(Digit), 0);
        release_reset();
        repeat (4 * TP) @(negedge Clk);

        for (int n = 0; n < 20; n++) begin
            case ($urandom_range(0, 2))
                0: press(1, 0, $urandom_range(0, 3));
                1: press(0, 1, $urandom_range(0, 3));
                default: press(1, 1, 0);
            endcase
            repeat ($urandom_range(1, 8) * TP) @(negedge Clk);
        end
        repeat (2) @(negedge Clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
